// File: rtl/seq_shift_add_mult_if.sv
// Operand/handshake bundle for seq_shift_add_mult: start/busy/done plus operand and product buses.
interface seq_shift_add_mult_if #(
   parameter int unsigned WIDTH = 8
);
   logic                   start;
   logic [WIDTH-1:0]       multiplicand;
   logic [WIDTH-1:0]       multiplier;
   logic                   busy;
   logic                   done;
   logic [2*WIDTH-1:0]     product;

   modport master (
      output start, multiplicand, multiplier,
      input  busy, done, product
   );

   modport slave (
      input  start, multiplicand, multiplier,
      output busy, done, product
   );
endinterface

// File: rtl/seq_shift_add_mult.sv
// Multi-cycle shift-and-add multiplier, one partial product per clock, start/busy/done handshake.
// Define MULT_SIGNED_EN for two's-complement operands/product (default build is unsigned).
module seq_shift_add_mult #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   seq_shift_add_mult_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t               r_state;
   state_t               w_next;
   logic [WIDTH-1:0]     r_mcand;
   logic [WIDTH-1:0]     r_mplr;
   logic [WIDTH-1:0]     r_acc;
   logic [CW-1:0]        r_cnt;
   logic                 r_done;
   logic [2*WIDTH-1:0]   r_product;
   logic                 w_load;
   logic                 w_step;
   logic                 w_finish;
   logic                 w_busy;
   logic [WIDTH:0]       w_sum;
   logic [2*WIDTH-1:0]   w_raw;
   logic [2*WIDTH-1:0]   w_result;
   logic [WIDTH-1:0]     w_op_a;
   logic [WIDTH-1:0]     w_op_b;

`ifdef MULT_SIGNED_EN
   logic                 r_neg;

   // Magnitudes: the most negative value maps onto 2^(WIDTH-1) as an unsigned quantity.
   always_comb begin
      w_op_a = bus.multiplicand[WIDTH-1] ? -bus.multiplicand : bus.multiplicand;
      w_op_b = bus.multiplier[WIDTH-1]   ? -bus.multiplier   : bus.multiplier;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_neg <= 1'b0;
      end else if (w_load) begin
         r_neg <= bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1];
      end
   end

   always_comb begin
      w_result = r_neg ? -w_raw : w_raw;
   end
`else
   always_comb begin
      w_op_a   = bus.multiplicand;
      w_op_b   = bus.multiplier;
      w_result = w_raw;
   end
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_next = RUN;
         RUN:     if (r_cnt == CW'(1)) w_next = FINISH;
         FINISH:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      w_load   = (r_state == IDLE) && bus.start;
      w_step   = (r_state == RUN);
      w_finish = (r_state == FINISH);
      w_busy   = (r_state != IDLE);
   end

   // One extra sum bit keeps the carry, which shifts into the accumulator MSB.
   always_comb begin
      w_sum = {1'b0, r_acc} + (r_mplr[0] ? {1'b0, r_mcand} : '0);
      w_raw = {r_acc, r_mplr};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mcand   <= '0;
         r_mplr    <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_done    <= 1'b0;
         r_product <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_load) begin
            r_mcand <= w_op_a;
            r_mplr  <= w_op_b;
            r_acc   <= '0;
            r_cnt   <= CW'(WIDTH);
         end else if (w_step) begin
            r_acc  <= w_sum[WIDTH:1];
            r_mplr <= {w_sum[0], r_mplr[WIDTH-1:1]};
            r_cnt  <= r_cnt - CW'(1);
         end else if (w_finish) begin
            r_product <= w_result;
            r_done    <= 1'b1;
         end
      end
   end

   assign bus.busy    = w_busy;
   assign bus.done    = r_done;
   assign bus.product = r_product;
endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Scoreboard bench for seq_shift_add_mult: driver queues expected products, monitor checks on done.
module tb_seq_shift_add_mult;
   localparam int unsigned W = 8;

   typedef struct {
      logic [2*W-1:0] p;
      int             t;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   seq_shift_add_mult_if #(.WIDTH(W)) bus ();

   seq_shift_add_mult #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued expectation, value and timing.
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("product", 32'(bus.product), 32'(e.p));
            check("latency", 32'(cyc), 32'(e.t));
         end
      end
   end

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] e);
      exp_t x;
      bus.start        = 1'b1;
      bus.multiplicand = a;
      bus.multiplier   = b;
      x.p = e;
      x.t = cyc + W + 2;
      q.push_back(x);
      @(posedge clk); #1;
      bus.start        = 1'b0;
      bus.multiplicand = W'($urandom);
      bus.multiplier   = W'($urandom);
      check("busy_after_start", 32'(bus.busy), 32'd1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         if (q.size() == 0 && bus.busy === 1'b0) break;
         @(posedge clk); #1;
      end
      check("drain", 32'(q.size()), 32'd0);
   endtask

   task automatic wait_done_cycle();
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) break;
      end
      check("done_seen", 32'(bus.done), 32'd1);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      bus.start        = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier   = '0;

      // Reset held for two edges
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_product", 32'(bus.product), 32'h0000);
      rst_n = 1'b1;
      idle_cycles(5);
      check("idle_busy", 32'(bus.busy), 32'd0);

      start_op(8'd13, 8'd11, 16'h008F);
      wait_idle();

      // Back-to-back: second start issued in the done cycle
`ifdef MULT_SIGNED_EN
      start_op(8'd255, 8'd255, 16'h0001);
`else
      start_op(8'd255, 8'd255, 16'hFE01);
`endif
      wait_done_cycle();
      start_op(8'd0, 8'd200, 16'h0000);
      wait_idle();

      // Start while busy is ignored
      start_op(8'd7, 8'd6, 16'h002A);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.multiplicand = 8'd9; bus.multiplier = 8'd9;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("busy_ignored_start", 32'(bus.busy), 32'd1);
      wait_idle();
      idle_cycles(12);

      // Reset mid-operation: low at E4 aborts with no done
      start_op(8'd100, 8'd3, 16'h012C);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      q.delete();
      @(posedge clk); #1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_product", 32'(bus.product), 32'h0000);
      check("abort_done", 32'(bus.done), 32'd0);
      rst_n = 1'b1;
      idle_cycles(15);
      start_op(8'd100, 8'd3, 16'h012C);
      wait_idle();

`ifdef MULT_SIGNED_EN
      start_op(8'hFD, 8'h05, 16'hFFF1);
      wait_idle();
      start_op(8'h80, 8'h80, 16'h4000);
      wait_idle();
      start_op(8'h80, 8'h01, 16'hFF80);
      wait_idle();
`else
      start_op(8'hFD, 8'h05, 16'h04F1);
      wait_idle();
      start_op(8'h80, 8'h80, 16'h4000);
      wait_idle();
      start_op(8'h80, 8'h01, 16'h0080);
      wait_idle();
`endif
      check("product_held", 32'(bus.product), 32'(q.size() == 0 ?
`ifdef MULT_SIGNED_EN
         16'hFF80
`else
         16'h0080
`endif
         : 16'hxxxx));
      idle_cycles(12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
